// File: rtl/lfsr.sv
// Free-running maximal-length Fibonacci LFSR. Advances one step per clock and
// exposes the low OUT_W bits of its state as rnd. The all-zero state is never
// reachable in normal operation, but is steered back to 1 if it ever appears.
module lfsr #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);

    // Mask with a single bit set for 1-based tap number n (0 means no tap).
    function automatic logic [31:0] tap_bit(input int unsigned n);
        return (n == 0) ? 32'd0 : (32'd1 << (n - 1));
    endfunction

    // Maximal-length tap sets, 1-based bit numbers, for widths 3..32.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        logic [31:0] m;
        m = '0;
        case (w)
            3:  m = tap_bit(3)  | tap_bit(2);
            4:  m = tap_bit(4)  | tap_bit(3);
            5:  m = tap_bit(5)  | tap_bit(3);
            6:  m = tap_bit(6)  | tap_bit(5);
            7:  m = tap_bit(7)  | tap_bit(6);
            8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  m = tap_bit(9)  | tap_bit(5);
            10: m = tap_bit(10) | tap_bit(7);
            11: m = tap_bit(11) | tap_bit(9);
            12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: m = tap_bit(15) | tap_bit(14);
            16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: m = tap_bit(17) | tap_bit(14);
            18: m = tap_bit(18) | tap_bit(11);
            19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: m = tap_bit(20) | tap_bit(17);
            21: m = tap_bit(21) | tap_bit(19);
            22: m = tap_bit(22) | tap_bit(21);
            23: m = tap_bit(23) | tap_bit(18);
            24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: m = tap_bit(25) | tap_bit(22);
            26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: m = tap_bit(28) | tap_bit(25);
            29: m = tap_bit(29) | tap_bit(27);
            30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: m = tap_bit(31) | tap_bit(28);
            32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    // Reject unsupported geometries at elaboration.
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "lfsr: WIDTH must be in 3..32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $fatal(1, "lfsr: OUT_W must be in 1..WIDTH");
    end

    localparam logic [31:0]      TAPS     = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] SEED_M   = WIDTH'(SEED);
    // A zero seed would lock the register up, so it is replaced by 1.
    localparam logic [WIDTH-1:0] EFF_SEED = (SEED_M == '0) ? WIDTH'(1) : SEED_M;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic             fb;

    // Feedback and next state, with recovery from the all-zero lock-up state.
    always_comb begin
        fb         = ^(state & TAPS[WIDTH-1:0]);
        state_next = {state[WIDTH-2:0], fb};
        if (state == '0) begin
            state_next = WIDTH'(1);
        end
    end

    // State register: seed while reset is low, otherwise advance every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EFF_SEED;
        end else begin
            state <= state_next;
        end
    end

    assign rnd = state[OUT_W-1:0];

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: table-driven default sequence, full-period
// check at width 8, seed masking, lock-up recovery, async reset pulses and
// randomized reset activity against a tap-list reference model.
module tb_lfsr;

    logic clk = 1'b0;
    logic reset_a, reset_b, reset_c, reset_r;

    logic [2:0]  rnd_a;
    logic [7:0]  rnd_b;
    logic [2:0]  rnd_c;
    logic [4:0]  rnd_d;
    logic [31:0] rnd_e;

    int tests  = 0;
    int failed = 0;

    localparam int unsigned SEED_D = 32'hACE1;

    always #5 clk = ~clk;

    lfsr dut_a (.clk(clk), .reset(reset_a), .rnd(rnd_a));

    lfsr #(.WIDTH(8), .OUT_W(8), .SEED(1)) dut_b (.clk(clk), .reset(reset_b), .rnd(rnd_b));

    lfsr #(.WIDTH(3), .OUT_W(3), .SEED(8)) dut_c (.clk(clk), .reset(reset_c), .rnd(rnd_c));

    lfsr #(.WIDTH(16), .OUT_W(5), .SEED(SEED_D)) dut_d (
        .clk(clk), .reset(reset_r), .rnd(rnd_d)
    );

    lfsr #(.WIDTH(32), .OUT_W(32), .SEED(0)) dut_e (.clk(clk), .reset(reset_r), .rnd(rnd_e));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step: shift left, feed back the XOR of the listed 1-based taps.
    function automatic logic [63:0] model_next(input int w, input logic [63:0] s);
        int          taps[4];
        logic        fb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if ((s & mask) == 64'd0) return 64'd1;
        case (w)
            3:       taps = '{3, 2, 0, 0};
            8:       taps = '{8, 6, 5, 4};
            16:      taps = '{16, 15, 13, 4};
            32:      taps = '{32, 22, 2, 1};
            default: taps = '{0, 0, 0, 0};
        endcase
        fb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (taps[i] != 0) fb = fb ^ s[taps[i] - 1];
        end
        return ((s << 1) | {63'd0, fb}) & mask;
    endfunction

    typedef struct {
        logic       rst;
        logic [2:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[17];
        logic [2:0]  seq[7];
        logic [63:0] mb, md, me;
        bit          seen[256];
        int          distinct;

        seq = '{3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 3'd1};
        for (int i = 0; i < 14; i++) tbl[3 + i] = '{1'b1, seq[i % 7]};

        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        reset_r = 1'b1;
        #1;
        reset_b = 1'b0;
        reset_c = 1'b0;
        reset_r = 1'b0;
        #1;
        reset_a = 1'b0;  // between edges: no clock needed to load the seed
        #1;
        check("a_async_reset", 32'(rnd_a), 32'd1);
        check("c_seed_masked", 32'(rnd_c), 32'd1);

        // Default instance: hold in reset, then run the sequence twice.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset_a = tbl[i].rst;
            @(posedge clk);
            #1;
            check($sformatf("a_vec%0d", i), 32'(rnd_a), 32'(tbl[i].exp));
            check($sformatf("a_nonzero%0d", i), 32'(rnd_a != 3'd0), 32'd1);
        end

        // Advance to rnd=7, then pulse reset for 3 of 10 time units off-edge.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("a_mid_seq", 32'(rnd_a), 32'd7);
        #1;
        reset_a = 1'b0;
        #1;
        check("a_pulse_async", 32'(rnd_a), 32'd1);
        #2;
        reset_a = 1'b1;
        #1;
        check("a_pulse_hold", 32'(rnd_a), 32'd1);
        @(posedge clk);
        #1;
        check("a_after_pulse", 32'(rnd_a), 32'd2);

        // Lock-up recovery from an all-zero state.
        @(negedge clk);
        force dut_a.state = 3'b000;
        #1;
        release dut_a.state;
        #1;
        check("a_forced_zero", 32'(rnd_a), 32'd0);
        @(posedge clk);
        #1;
        check("a_lockup_exit", 32'(dut_a.state), 32'd1);

        // Seed-masked instance: first edge after release gives 2.
        @(negedge clk);
        check("c_hold", 32'(rnd_c), 32'd1);
        reset_c = 1'b1;
        @(posedge clk);
        #1;
        check("c_first_step", 32'(rnd_c), 32'd2);

        // Width 8: full period, every nonzero value exactly once.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        mb = 64'd1;
        @(negedge clk);
        check("b_seed", 32'(rnd_b), 32'd1);
        reset_b = 1'b1;
        for (int e = 1; e <= 255; e++) begin
            @(posedge clk);
            #1;
            mb = model_next(8, mb);
            check($sformatf("b_model%0d", e), 32'(rnd_b), mb[31:0]);
            if (rnd_b == 8'd0 || seen[rnd_b]) begin
                check($sformatf("b_unique%0d", e), 32'(rnd_b), 32'hFFFF_FFFF);
            end else begin
                seen[rnd_b] = 1'b1;
                distinct++;
            end
        end
        check("b_distinct", 32'(distinct), 32'd255);
        check("b_period_wrap", 32'(dut_b.state), 32'd1);

        // Randomized reset activity on the 16- and 32-bit instances.
        md = 64'(SEED_D);
        me = 64'd1;
        @(negedge clk);
        check("d_seed", 32'(rnd_d), md[31:0] & 32'h1F);
        check("e_zero_seed", rnd_e, 32'd1);
        reset_r = 1'b1;
        for (int it = 0; it < 300; it++) begin
            @(posedge clk);
            if (reset_r) begin
                md = model_next(16, md);
                me = model_next(32, me);
            end
            #1;
            check("rand_w16", 32'(rnd_d), md[31:0] & 32'h1F);
            check("rand_w32", rnd_e, me[31:0]);
            if ($urandom_range(0, 15) == 0) begin
                #($urandom_range(1, 3));
                reset_r = 1'b0;
                md = 64'(SEED_D);
                me = 64'd1;
                #1;
                check("rand_rst_w16", 32'(rnd_d), md[31:0] & 32'h1F);
                check("rand_rst_w32", rnd_e, me[31:0]);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #($urandom_range(2, 4));
                reset_r = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
